// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Auto-repeat constants are used only when KEYPAD_REPEAT_EN is defined.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    typedef struct packed {
        logic       none;
        logic       multi;
        logic [3:0] idx;
    } key_code_t;

    localparam logic [3:0] NUM_IDLE = 4'hF;

    localparam int CHAR_A = 0;
    localparam int CHAR_B = 1;
    localparam int CHAR_C = 2;

    localparam int REPEAT_FIRST = 64;
    localparam int REPEAT_NEXT  = 16;
    localparam int RPT_W        = 7;

endpackage

// File: rtl/keypad_decode.sv
// Combinational frame decoder: 16-bit key image to key code and
// single/none/multi flags. Bit index is row*4+col, 1 = key down.
module keypad_decode
    import keypad_pkg::*;
(
    input  logic [15:0] frame,
    output key_code_t   code,
    output logic        single,
    output logic        none,
    output logic        multi
);

    logic [4:0] cnt;
    logic [3:0] idx;

    always_comb begin
        cnt = '0;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame[i]) begin
                cnt = cnt + 5'd1;
                idx = 4'(i);
            end
        end
        none       = (cnt == 5'd0);
        single     = (cnt == 5'd1);
        multi      = (cnt > 5'd1);
        code.none  = none;
        code.multi = multi;
        code.idx   = single ? idx : 4'h0;
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with frame debounce and one-cycle key pulses.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] KEY_ROW,
    output logic [3:0] KEY_COL,
    output logic [3:0] NUM_SYNC,
    output logic [2:0] CHAR_SYNC
);

    localparam logic [7:0] SLOT_LAST = 8'(SCAN_DIV - 1);
    localparam logic [3:0] DEB_MAX   = 4'(DEBOUNCE);

    logic [3:0]  row_meta;
    logic [3:0]  row_sync;
    logic [7:0]  slot;
    logic [1:0]  col;
    logic [15:0] frame_q;
    logic [15:0] frame_now;
    logic        sample;
    logic        frame_end;

    key_code_t   code;
    logic        single;
    logic        none_f;
    logic        multi_f;

    state_t      state;
    state_t      state_n;
    logic [3:0]  cand;
    logic [3:0]  cand_n;
    logic [3:0]  deb;
    logic [3:0]  deb_n;
    logic [3:0]  deb_inc;
    logic        emit;
    logic        rpt_emit;
    logic        fire;
    logic [3:0]  digit;
    logic [2:0]  chr;

    assign sample    = (slot == SLOT_LAST);
    assign frame_end = sample && (col == 2'd3);
    assign KEY_COL   = ~(4'b0001 << col);
    assign deb_inc   = (deb == 4'hF) ? deb : deb + 4'd1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
            slot     <= '0;
            col      <= '0;
            frame_q  <= '0;
        end else begin
            row_meta <= KEY_ROW;
            row_sync <= row_meta;
            if (sample) begin
                slot    <= '0;
                col     <= col + 2'd1;
                frame_q <= frame_now;
            end else begin
                slot <= slot + 8'd1;
            end
        end
    end

    // Current column's rows merged into the partially built frame image
    always_comb begin
        frame_now = frame_q;
        for (int r = 0; r < 4; r++) begin
            frame_now[{2'(r), col}] = ~row_sync[r];
        end
    end

    keypad_decode u_decode (
        .frame  (frame_now),
        .code   (code),
        .single (single),
        .none   (none_f),
        .multi  (multi_f)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cand  <= '0;
            deb   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            deb   <= deb_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        deb_n   = deb;
        emit    = 1'b0;
        if (frame_end) begin
            unique case (state)
                IDLE: begin
                    if (single) begin
                        state_n = DEB_PRESS;
                        cand_n  = code.idx;
                        deb_n   = 4'd1;
                    end
                end
                DEB_PRESS: begin
                    if (code.none || code.multi || code.idx != cand) begin
                        state_n = IDLE;
                        deb_n   = '0;
                    end else if (deb >= DEB_MAX) begin
                        state_n = HELD;
                        deb_n   = '0;
                        emit    = 1'b1;
                    end else begin
                        deb_n = deb_inc;
                    end
                end
                HELD: begin
                    if (none_f || multi_f) begin
                        state_n = DEB_RELEASE;
                        deb_n   = 4'd1;
                    end
                end
                DEB_RELEASE: begin
                    if (single) begin
                        state_n = HELD;
                        deb_n   = '0;
                    end else if (deb >= DEB_MAX) begin
                        state_n = IDLE;
                        deb_n   = '0;
                    end else begin
                        deb_n = deb_inc;
                    end
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [RPT_W-1:0] rpt;
    logic [RPT_W-1:0] rpt_n;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rpt <= '0;
        end else begin
            rpt <= rpt_n;
        end
    end

    // First repeat after 64 held frames, then every 16 by rewinding
    always_comb begin
        rpt_n    = rpt;
        rpt_emit = 1'b0;
        if (state != HELD) begin
            rpt_n = '0;
        end else if (frame_end && single) begin
            if (rpt == RPT_W'(REPEAT_FIRST - 1)) begin
                rpt_emit = 1'b1;
                rpt_n    = RPT_W'(REPEAT_FIRST - REPEAT_NEXT);
            end else begin
                rpt_n = rpt + 1'b1;
            end
        end
    end
`else
    assign rpt_emit = 1'b0;
`endif

    assign fire = emit || rpt_emit;

    always_comb begin
        digit = NUM_IDLE;
        chr   = '0;
        unique case (cand)
            4'd0:    digit = 4'd1;
            4'd1:    digit = 4'd2;
            4'd2:    digit = 4'd3;
            4'd3:    chr[CHAR_A] = 1'b1;
            4'd4:    digit = 4'd4;
            4'd5:    digit = 4'd5;
            4'd6:    digit = 4'd6;
            4'd7:    chr[CHAR_B] = 1'b1;
            4'd8:    digit = 4'd7;
            4'd9:    digit = 4'd8;
            4'd10:   digit = 4'd9;
            4'd11:   chr[CHAR_C] = 1'b1;
            4'd13:   digit = 4'd0;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            NUM_SYNC  <= NUM_IDLE;
            CHAR_SYNC <= '0;
        end else begin
            NUM_SYNC  <= fire ? digit : NUM_IDLE;
            CHAR_SYNC <= fire ? chr : 3'b000;
        end
    end

endmodule
